// File: rtl/seq_multiplier_16_if.sv
// Handshake bundle for the sequential multiplier: request side (start, operands)
// and response side (busy, done, registered product).
interface seq_multiplier_16_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_multiplier_16.sv
// Shift-and-add unsigned multiplier: one partial product per RUN cycle through a
// carry-lookahead adder, fixed WIDTH-cycle latency, one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; product holds last result
// RUN   | one add/shift iteration per cycle, cnt = iteration index
// DONE  | product valid, done high for this single cycle; start here chains a new op
module seq_multiplier_16 #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    seq_multiplier_16_if.slave  bus
);

    localparam int NGRP = WIDTH / 4;
    localparam int CW   = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       m_reg;
    // The accumulator's MSB is always zero after the logical shift, so it is not stored.
    logic [2*WIDTH-1:0]     p_reg;
    logic                   busy_r;
    logic                   done_r;
    logic [2*WIDTH-1:0]     product_r;

    logic [WIDTH:0]         sum_w;
    logic [2*WIDTH-1:0]     p_next;

    // Carry-lookahead inside each 4-bit group; group generate/propagate chain the groups.
    always_comb begin : cla_add
        logic [WIDTH-1:0] addend;
        logic [WIDTH-1:0] acc_hi;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] c;
        logic             carry;
        logic             gg;
        logic             pg;
        int               b;
        addend = p_reg[0] ? m_reg : '0;
        acc_hi = p_reg[2*WIDTH-1:WIDTH];
        g      = acc_hi & addend;
        p      = acc_hi ^ addend;
        c      = '0;
        carry  = 1'b0;
        gg     = 1'b0;
        pg     = 1'b0;
        b      = 0;
        for (int j = 0; j < NGRP; j++) begin
            b        = 4 * j;
            c[b]     = carry;
            c[b+1]   = g[b] | (p[b] & carry);
            c[b+2]   = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & carry);
            c[b+3]   = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
                     | (p[b+2] & p[b+1] & p[b] & carry);
            gg       = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1])
                     | (p[b+3] & p[b+2] & p[b+1] & g[b]);
            pg       = &p[b +: 4];
            carry    = gg | (pg & carry);
        end
        sum_w = {carry, p ^ c};
    end

    assign p_next = {sum_w, p_reg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            m_reg     <= '0;
            p_reg     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        m_reg  <= bus.multiplicand;
                        p_reg  <= {{WIDTH{1'b0}}, bus.multiplier};
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    p_reg <= p_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= p_next;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule

// File: tb/tb_seq_multiplier_16.sv
// Scoreboard bench for seq_multiplier_16: driver pushes A*B with its due cycle,
// a negedge monitor checks busy, done timing and product against the queue.
module tb_seq_multiplier_16;

    typedef struct {
        logic [31:0] prod;
        int          done_cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;
    logic [31:0] last_exp;
    exp_t exp_q[$];

    seq_multiplier_16_if #(.WIDTH(16)) mif ();

    seq_multiplier_16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin : monitor
        logic busy_exp;
        exp_t e;
        if (!reset_n) last_exp = 32'h0;
        busy_exp = (exp_q.size() > 0) && (cyc >= exp_q[0].done_cyc - 16) && (cyc < exp_q[0].done_cyc);
        check("busy", 32'(mif.busy), 32'(busy_exp));
        if (mif.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(mif.done), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("product", mif.product, e.prod);
                last_exp = e.prod;
            end
        end else begin
            if (exp_q.size() > 0 && cyc >= exp_q[0].done_cyc) begin
                check("done_missing", 32'(mif.done), 32'h1);
                e = exp_q.pop_front();
            end
            check("product_hold", mif.product, last_exp);
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        mif.start        = 1'b1;
        mif.multiplicand = a;
        mif.multiplier   = b;
        e.prod           = 32'(a) * 32'(b);
        e.done_cyc       = cyc + 17;
        exp_q.push_back(e);
        @(negedge clk);
        mif.start        = 1'b0;
        mif.multiplicand = 16'($urandom);
        mif.multiplier   = 16'($urandom);
    endtask

    // One operation; inj in 0..14 fires an ignored start at that RUN offset, -1 = none.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input int inj, input int gap);
        issue(a, b);
        if (inj < 0) begin
            repeat (16) @(negedge clk);
        end else begin
            repeat (inj) @(negedge clk);
            mif.start        = 1'b1;
            mif.multiplicand = 16'($urandom);
            mif.multiplier   = 16'($urandom);
            @(negedge clk);
            mif.start        = 1'b0;
            repeat (15 - inj) @(negedge clk);
        end
        repeat (gap) @(negedge clk);
    endtask

    function automatic logic [15:0] rand_operand();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel == 0) return 16'hFFFF;
        if (sel == 1) return 16'h0000;
        return 16'($urandom);
    endfunction

    initial begin
        exp_t e;
        checks           = 0;
        errors           = 0;
        last_exp         = 32'h0;
        reset_n          = 1'b0;
        mif.start        = 1'b0;
        mif.multiplicand = 16'h0;
        mif.multiplier   = 16'h0;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(mif.busy), 32'h0);
        check("reset_done", 32'(mif.done), 32'h0);
        check("reset_product", mif.product, 32'h0);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);

        op(16'd3, 16'd5, -1, 2);
        op(16'hFFFF, 16'hFFFF, -1, 0);
        op(16'h0000, 16'h1234, -1, 3);

        // Start during RUN cycle 5 must be ignored.
        op(16'd7, 16'd9, 4, 2);

        // Start held high: one accepted operation every 17 cycles.
        mif.start        = 1'b1;
        mif.multiplicand = 16'h0100;
        mif.multiplier   = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            e.prod     = 32'h0001_0000;
            e.done_cyc = cyc + 17;
            exp_q.push_back(e);
            repeat (17) @(negedge clk);
        end
        mif.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in RUN cycle 8 aborts; start during reset is ignored.
        issue(16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        mif.start = 1'b1;
        #1;
        check("abort_busy", 32'(mif.busy), 32'h0);
        check("abort_done", 32'(mif.done), 32'h0);
        check("abort_product", mif.product, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        issue(16'h1234, 16'h5678);
        repeat (16) @(negedge clk);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            op(rand_operand(), rand_operand(),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 14)) : -1,
               int'($urandom_range(0, 3)));
        end

        for (int t = 0; t < 40 && exp_q.size() > 0; t++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
